// File: rtl/calc_pkg.sv
// Shared types for the calculator datapath: step codes, opcodes, flag bit positions
// and the multiplier FSM state encoding.
package calc_pkg;

    typedef enum logic [1:0] {
        WAIT_OP1       = 2'd0,
        WAIT_OP2       = 2'd1,
        WAIT_OPERATION = 2'd2,
        SHOW_RESULT    = 2'd3
    } step_e;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_AND  = 3'b010,
        OP_OR   = 3'b011,
        OP_XOR  = 3'b100,
        OP_SHL  = 3'b101,
        OP_MUL  = 3'b110,
        OP_RSVD = 3'b111
    } opcode_e;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'd0,
        MUL_RUN  = 2'd1,
        MUL_DONE = 2'd2
    } mul_state_e;

    localparam int FLAG_CARRY = 0;
    localparam int FLAG_ZERO  = 1;
    localparam int FLAG_NEG   = 2;
    localparam int FLAG_ERR   = 3;

endpackage

// File: rtl/calc_seq_mul.sv
// Shift-add multiplier: one partial product per cycle for WIDTH cycles, then one DONE cycle.
module calc_seq_mul
    import calc_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH + 1);

    mul_state_e         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q  <= MUL_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = MUL_IDLE;
        end else begin
            case (state_q)
                MUL_IDLE: if (start) state_d = MUL_RUN;
                // counter hits zero on this step's decrement
                MUL_RUN:  if (cnt_q == CW'(1)) state_d = MUL_DONE;
                MUL_DONE: state_d = MUL_IDLE;
                default:  state_d = MUL_IDLE;
            endcase
        end
    end

    always_comb begin
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        if (state_q == MUL_IDLE && start && !abort) begin
            cnt_d    = CW'(WIDTH);
            acc_d    = '0;
            mcand_d  = {{WIDTH{1'b0}}, a};
            mplier_d = b;
        end else if (state_q == MUL_RUN && !abort) begin
            if (mplier_q[0]) acc_d = acc_q + mcand_q;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - CW'(1);
        end
    end

    always_comb begin
        busy    = (state_q == MUL_RUN);
        done    = (state_q == MUL_DONE);
        product = acc_q;
    end

endmodule

// File: rtl/calc_datapath.sv
// Calculator operand/result datapath driven by the step controller's code.
// Define CALC_MUL_EN to build the sequential multiplier for opcode 110.
module calc_datapath
    import calc_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             trigger,
    input  logic             undo,
    input  logic [1:0]       state_in,
    input  logic [WIDTH-1:0] data_in,
    input  logic [2:0]       op_in,
    output logic [WIDTH-1:0] op_a,
    output logic [WIDTH-1:0] op_b,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] display,
    output logic [3:0]       flags,
    output logic             busy,
    output logic             valid
);

    logic [WIDTH-1:0] op_a_q, op_a_d, op_b_q, op_b_d, result_q, result_d;
    logic [3:0]       flags_q, flags_d;
    logic             valid_q, valid_d;
    logic             mul_busy, trig_ev, undo_ev;
    step_e            step;

    function automatic logic [3:0] mk_flags(input logic [WIDTH-1:0] r, input logic c,
                                            input logic err);
        logic [3:0] f;
        f = '0;
        f[FLAG_ERR] = err;
        if (!err) begin
            f[FLAG_CARRY] = c;
            f[FLAG_ZERO]  = (r == '0);
            f[FLAG_NEG]   = r[WIDTH-1];
        end
        return f;
    endfunction

    // MUL lands in the error arm here; the multiplier path intercepts it when built.
    function automatic logic [WIDTH+3:0] alu(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                             input logic [2:0] op);
        logic [WIDTH:0]     sum;
        logic [2*WIDTH-1:0] wide;
        logic [WIDTH-1:0]   r;
        logic               c, err;
        sum = '0; wide = '0; r = '0; c = 1'b0; err = 1'b0;
        case (opcode_e'(op))
            OP_ADD: begin sum = {1'b0, a} + {1'b0, b}; r = sum[WIDTH-1:0]; c = sum[WIDTH]; end
            OP_SUB: begin r = a - b; c = (a < b); end
            OP_AND: r = a & b;
            OP_OR:  r = a | b;
            OP_XOR: r = a ^ b;
            OP_SHL: begin
                wide = {{WIDTH{1'b0}}, a} << b[3:0];
                r    = wide[WIDTH-1:0];
                c    = |wide[2*WIDTH-1:WIDTH];
            end
            default: err = 1'b1;
        endcase
        return {mk_flags(r, c, err), r};
    endfunction

    assign step    = step_e'(state_in);
    assign trig_ev = trigger && !undo && !mul_busy;
    assign undo_ev = undo && !trigger;

`ifdef CALC_MUL_EN
    logic               mul_start, mul_abort, mul_done;
    logic [2*WIDTH-1:0] product;

    assign mul_start = trig_ev && step == WAIT_OPERATION && op_in == OP_MUL;
    assign mul_abort = undo_ev && step == SHOW_RESULT;

    calc_seq_mul #(.WIDTH(WIDTH)) u_mul (
        .clock   (clock),
        .reset   (reset),
        .start   (mul_start),
        .abort   (mul_abort),
        .a       (op_a_q),
        .b       (op_b_q),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (product)
    );
`else
    assign mul_busy = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (!reset) begin
            op_a_q   <= '0;
            op_b_q   <= '0;
            result_q <= '0;
            flags_q  <= '0;
            valid_q  <= 1'b0;
        end else begin
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            result_q <= result_d;
            flags_q  <= flags_d;
            valid_q  <= valid_d;
        end
    end

    always_comb begin
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        result_d = result_q;
        flags_d  = flags_q;
        valid_d  = valid_q;
        if (trig_ev) begin
            case (step)
                WAIT_OP1: op_a_d = data_in;
                WAIT_OP2: op_b_d = data_in;
                WAIT_OPERATION: begin
`ifdef CALC_MUL_EN
                    if (op_in == OP_MUL) begin
                        result_d = '0;
                        flags_d  = '0;
                        valid_d  = 1'b0;
                    end else
`endif
                    begin
                        {flags_d, result_d} = alu(op_a_q, op_b_q, op_in);
                        valid_d = 1'b1;
                    end
                end
                default: begin
                    op_a_d   = '0;
                    op_b_d   = '0;
                    result_d = '0;
                    flags_d  = '0;
                    valid_d  = 1'b0;
                end
            endcase
        end else if (undo_ev) begin
            case (step)
                WAIT_OP1:       ;
                WAIT_OP2:       op_a_d = '0;
                WAIT_OPERATION: op_b_d = '0;
                default: begin
                    result_d = '0;
                    flags_d  = '0;
                    valid_d  = 1'b0;
                end
            endcase
        end
`ifdef CALC_MUL_EN
        if (mul_done && !mul_abort) begin
            result_d = product[WIDTH-1:0];
            flags_d  = mk_flags(product[WIDTH-1:0], |product[2*WIDTH-1:WIDTH], 1'b0);
            valid_d  = 1'b1;
        end
`endif
    end

    always_comb begin
        case (step)
            WAIT_OP1, WAIT_OP2: display = data_in;
            WAIT_OPERATION:     display = op_b_q;
            default:            display = valid_q ? result_q : '0;
        endcase
    end

    assign op_a   = op_a_q;
    assign op_b   = op_b_q;
    assign result = result_q;
    assign flags  = flags_q;
    assign valid  = valid_q;
    assign busy   = mul_busy;

endmodule

// File: tb/tb_calc_datapath.sv
// Scoreboard bench for calc_datapath (WIDTH=16); follows CALC_MUL_EN to pick MUL expectations.
module tb_calc_datapath;

`ifdef CALC_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        trigger = 1'b0, undo = 1'b0;
    logic [1:0]  state_in = 2'd0;
    logic [15:0] data_in = '0;
    logic [2:0]  op_in = '0;
    logic [15:0] op_a, op_b, result, display;
    logic [3:0]  flags;
    logic        busy, valid;

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic [15:0] res;
        logic [3:0]  flg;
        int          lat;
        int          bcyc;
    } exp_t;
    exp_t sb[$];

    calc_datapath #(.WIDTH(16)) dut (
        .clock(clock), .reset(reset), .trigger(trigger), .undo(undo),
        .state_in(state_in), .data_in(data_in), .op_in(op_in),
        .op_a(op_a), .op_b(op_b), .result(result), .display(display),
        .flags(flags), .busy(busy), .valid(valid)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op);
        exp_t        e;
        logic [31:0] w;
        logic [3:0]  sh;
        logic        c, err;
        e.lat = 1; e.bcyc = 0; w = '0; c = 1'b0; err = 1'b0; sh = b[3:0];
        case (op)
            3'd0: begin w = {16'h0, a} + {16'h0, b}; c = w[16]; end
            3'd1: begin w = {16'h0, a} - {16'h0, b}; c = (a < b); end
            3'd2: w = {16'h0, a & b};
            3'd3: w = {16'h0, a | b};
            3'd4: w = {16'h0, a ^ b};
            3'd5: begin w = {16'h0, a} << sh; c = (w[31:16] != 0); end
            3'd6: begin
                if (MUL_EN) begin
                    w = {16'h0, a} * {16'h0, b};
                    c = (w[31:16] != 0);
                    e.lat = 18; e.bcyc = 16;
                end else err = 1'b1;
            end
            default: err = 1'b1;
        endcase
        e.res = err ? 16'h0 : w[15:0];
        e.flg = err ? 4'b1000 : {1'b0, e.res[15], e.res == 16'h0, c};
        return e;
    endfunction

    task automatic pulse(input logic t, input logic u, input logic [1:0] st,
                         input logic [15:0] d, input logic [2:0] op);
        trigger = t; undo = u; state_in = st; data_in = d; op_in = op;
        @(posedge clock); #1;
        trigger = 1'b0; undo = 1'b0;
    endtask

    task automatic test_reset();
        state_in = 2'd0; data_in = 16'hA5A5; reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        total++; if ({op_a, op_b, result, flags, busy, valid} !== '0)
            $display("FAIL reset_state: got %h required 0", {op_a, op_b, result, flags, busy, valid});
        else passed++;
        total++; if (display !== 16'hA5A5) $display("FAIL reset_display: got %h required a5a5", display);
        else passed++;
        reset = 1'b1;
        @(posedge clock); #1;
    endtask

    task automatic test_capture();
        pulse(1, 0, 0, 16'h1234, 0);
        total++; if (op_a !== 16'h1234) $display("FAIL capture_a: got %h required 1234", op_a);
        else passed++;
        total++; if ({op_b, result, flags, busy, valid} !== '0)
            $display("FAIL capture_others: got %h required 0", {op_b, result, flags, busy, valid});
        else passed++;
        pulse(1, 0, 1, 16'h0042, 0);
        state_in = 2'd2; #1;
        total++; if (display !== 16'h0042) $display("FAIL display_state2: got %h required 0042", display);
        else passed++;
        pulse(1, 0, 3, 0, 0);
    endtask

    task automatic run_op(input string nm, input logic [15:0] a, input logic [15:0] b,
                          input logic [2:0] op);
        exp_t e;
        int   lat, bcyc;
        pulse(1, 0, 0, a, 0);
        pulse(1, 0, 1, b, 0);
        sb.push_back(model(a, b, op));
        pulse(1, 0, 2, 16'hDEAD, op);
        lat = 1; bcyc = 0;
        while (!valid && lat < 40) begin
            if (busy) bcyc++;
            @(posedge clock); #1;
            lat++;
        end
        e = sb.pop_front();
        total++; if (valid !== 1'b1) $display("FAIL %s_valid: got %b required 1", nm, valid);
        else passed++;
        total++; if (result !== e.res) $display("FAIL %s_result: got %h required %h", nm, result, e.res);
        else passed++;
        total++; if (flags !== e.flg) $display("FAIL %s_flags: got %b required %b", nm, flags, e.flg);
        else passed++;
        total++; if (lat != e.lat) $display("FAIL %s_latency: got %0d required %0d", nm, lat, e.lat);
        else passed++;
        total++; if (bcyc != e.bcyc) $display("FAIL %s_busy_cycles: got %0d required %0d", nm, bcyc, e.bcyc);
        else passed++;
        state_in = 2'd3; #1;
        total++; if (display !== e.res) $display("FAIL %s_display: got %h required %h", nm, display, e.res);
        else passed++;
        pulse(1, 0, 3, 0, 0);
        total++; if ({op_a, op_b, result, flags, valid} !== '0)
            $display("FAIL %s_clear: got %h required 0", nm, {op_a, op_b, result, flags, valid});
        else passed++;
    endtask

    task automatic test_alu();
        run_op("add_carry", 16'hFFFF, 16'h0001, 3'd0);
        run_op("sub_borrow", 16'd3, 16'd5, 3'd1);
        run_op("shl_out", 16'h8001, 16'h0004, 3'd5);
        run_op("rsvd", 16'h1111, 16'h2222, 3'd7);
        run_op("mul", 16'd300, 16'd300, 3'd6);
        for (int i = 0; i < 6; i++) begin
            logic [2:0] op;
            op = 3'($urandom_range(0, 5));
            run_op("rand", 16'($urandom), 16'($urandom), op);
        end
    endtask

    task automatic test_undo();
        pulse(1, 0, 0, 16'd5, 0);
        pulse(1, 0, 1, 16'd7, 0);
        pulse(0, 1, 2, 0, 0);
        total++; if (op_b !== 16'd0 || op_a !== 16'd5)
            $display("FAIL undo_state2: got a=%h b=%h required a=0005 b=0000", op_a, op_b);
        else passed++;
        pulse(0, 1, 1, 0, 0);
        total++; if (op_a !== 16'd0) $display("FAIL undo_state1: got %h required 0", op_a);
        else passed++;
        pulse(1, 0, 0, 16'd9, 0);
        pulse(1, 1, 0, 16'h0055, 0);
        total++; if (op_a !== 16'd9) $display("FAIL both_pulses: got %h required 0009", op_a);
        else passed++;
        pulse(0, 1, 0, 16'h0077, 0);
        total++; if (op_a !== 16'd9) $display("FAIL undo_state0: got %h required 0009", op_a);
        else passed++;
        pulse(1, 0, 3, 0, 0);
    endtask

`ifdef CALC_MUL_EN
    task automatic test_mul_abort();
        pulse(1, 0, 0, 16'd300, 0);
        pulse(1, 0, 1, 16'd300, 0);
        pulse(1, 0, 2, 0, 3'd6);
        pulse(1, 0, 0, 16'hBEEF, 0);
        total++; if (op_a !== 16'd300 || busy !== 1'b1)
            $display("FAIL busy_ignores_trigger: got a=%h busy=%b required a=012c busy=1", op_a, busy);
        else passed++;
        repeat (2) begin @(posedge clock); #1; end
        pulse(0, 1, 3, 0, 0);
        total++; if (busy !== 1'b0) $display("FAIL abort_busy: got %b required 0", busy);
        else passed++;
        repeat (20) begin @(posedge clock); #1; end
        total++; if (valid !== 1'b0 || result !== 16'h0)
            $display("FAIL abort_no_result: got valid=%b result=%h required 0", valid, result);
        else passed++;
        pulse(1, 0, 2, 0, 3'd6);
        repeat (5) begin @(posedge clock); #1; end
        reset = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
        total++; if ({op_a, op_b, busy, valid} !== '0)
            $display("FAIL reset_mid_mul: got %h required 0", {op_a, op_b, busy, valid});
        else passed++;
        repeat (20) begin @(posedge clock); #1; end
        total++; if (valid !== 1'b0) $display("FAIL reset_mid_mul_valid: got %b required 0", valid);
        else passed++;
    endtask
`endif

    initial begin
        test_reset();
        test_capture();
        test_alu();
        test_undo();
`ifdef CALC_MUL_EN
        test_mul_abort();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/calc_datapath.md
# calc_datapath

Operand/result datapath for the calculator. It sits beside the step controller and consumes that controller's 2-bit step code together with the same `trigger`/`undo` pulses. It captures operand A, operand B and the opcode from the switch inputs, computes the result (single-cycle ALU ops, multi-cycle shift-add multiply), supports undo of each captured step, and drives the value shown on the display.

## Interface
Parameters:
- `WIDTH`, 16: operand/result width.

Ports:
- `clock`, in, 1: system clock; all state updates on its rising edge.
- `reset`, in, 1: synchronous, active-low.
- `trigger`, in, 1: single-cycle advance pulse, already debounced and edge-detected.
- `undo`, in, 1: single-cycle step-back pulse, already debounced and edge-detected.
- `state_in`, in, 2: controller registered step code. 0 = wait_op1, 1 = wait_op2, 2 = wait_operation, 3 = show_result.
- `data_in`, in, WIDTH: switch value.
- `op_in`, in, 3: opcode switches.
- `op_a`, out, WIDTH: captured operand A.
- `op_b`, out, WIDTH: captured operand B.
- `result`, out, WIDTH: registered result.
- `display`, out, WIDTH: value to show.
- `flags`, out, 4: {err, neg, zero, carry} for the result.
- `busy`, out, 1: multiply in progress.
- `valid`, out, 1: `result` and `flags` are meaningful.

## Operation
- An event is a cycle in which exactly one of `trigger`/`undo` is high. When both are high, or neither is, nothing changes.
- Each event acts according to `state_in` sampled in the same cycle.
- Trigger actions, by `state_in`:
  - 0: `op_a` <= `data_in`.
  - 1: `op_b` <= `data_in`.
  - 2: latch `op_in` and start the operation.
  - 3: clear `op_a`, `op_b`, `result`, `flags`, `valid`.
- Undo actions, by `state_in`:
  - 0: no-op.
  - 1: `op_a` <= 0.
  - 2: `op_b` <= 0.
  - 3: clear `result`, `flags`, `valid`; abort any multiply (`busy` <= 0).
- Opcodes:
  - 000 ADD.
  - 001 SUB (A−B).
  - 010 AND.
  - 011 OR.
  - 100 XOR.
  - 101 SHL (A << B[3:0]).
  - 110 MUL.
  - 111 reserved.
- Flags:
  - carry: ADD carry-out; SUB borrow (A<B); SHL any bit shifted out; MUL any nonzero bit above WIDTH. Otherwise 0.
  - zero: `result` == 0.
  - neg: `result[WIDTH-1]`.
  - err: reserved opcode. `result` is then 0 and the other flags are 0.
- Result is truncated to WIDTH bits and is unsigned modulo 2^WIDTH.
- Multiplier FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN on a MUL start. The counter loads WIDTH, the accumulator loads 0.
  - RUN: each cycle, if the multiplier LSB is 1, add the shifted multiplicand; shift; decrement the counter. RUN -> DONE when the counter reaches 0.
  - DONE -> IDLE after one cycle, writing `result`/`flags` and setting `valid`.
  - Undo in state 3 returns to IDLE from any state.
- While `busy`, trigger events are ignored.
- `display` by `state_in`: 0 and 1 show `data_in`; 2 shows `op_b`; 3 shows `result` if `valid`, else 0.

## Timing
- Reset value of all outputs: 0. This covers `op_a`, `op_b`, `result`, `flags`, `busy`, `valid`, and multiplier state IDLE. `display` then follows its mux.
- Operand capture: visible on `op_a`/`op_b` the cycle after the trigger.
- Single-cycle ops: `result`, `flags` and `valid` are updated the cycle after the trigger, so latency is 1.
- MUL:
  - `busy` = 1 from the cycle after the trigger, for WIDTH cycles.
  - `result`/`valid` update the cycle after `busy` falls, so latency is WIDTH+2.
- `display` is combinational from registers, `data_in` and `state_in`.
- Reset asserted mid-multiply: everything is cleared on that edge, with no partial result.

## Configuration
- `CALC_MUL_EN` defined: the multiplier FSM and accumulator are built; opcode 110 behaves as MUL above.
- `CALC_MUL_EN` undefined: no multiplier logic; `busy` is tied to 0; opcode 110 is treated as reserved (err = 1, `result` = 0, latency 1).

## Structure
- Package `calc_pkg`:
  - step-code enum matching the controller: wait_op1 = 0, wait_op2 = 1, wait_operation = 2, show_result = 3.
  - opcode enum.
  - flag bit index constants.
- Sub-module `calc_seq_mul`: the shift-add multiplier. Ports: start, abort, a, b, busy, done, product[2·WIDTH−1:0]. Instantiated only under `CALC_MUL_EN`.

## Test plan
All scenarios use WIDTH = 16.
- Reset, then trigger with `state_in` = 0, `data_in` = 0x1234 -> `op_a` = 0x1234 the next cycle; all other outputs are 0.
- A = 0xFFFF, B = 0x0001, trigger in state 2 with op 000 -> `result` = 0x0000, flags = {0,0,1,1}, `valid` = 1 one cycle later.
- A = 3, B = 5, op 001 -> `result` = 0xFFFE, carry = 1, neg = 1.
- With `CALC_MUL_EN`: A = 300, B = 300, op 110 -> `busy` high 16 cycles, then `result` = 0x5F90, carry = 1, `valid` = 1 at cycle 18. Undo at cycle 5 of the same run -> `busy` = 0, `valid` stays 0.
- Undo sequence:
  - undo in state 2 -> `op_b` = 0.
  - undo in state 1 -> `op_a` = 0.
  - trigger and undo in the same cycle -> no change.
- Op 111 (and op 110 without the macro) -> `result` = 0, err = 1, `valid` = 1 after 1 cycle. A subsequent trigger in state 3 clears all outputs.
